// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the load/store port and the
// memory macro port of the shared-memory arbiter.
//   slave  : the arbiter side
//   master : the core/memory side (requesters and the memory macro)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store port
    logic              d_req;
    logic [BE_W-1:0]   d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Unified memory macro port
    logic              mem_en;
    logic [BE_W-1:0]   mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port synchronous memory between the
// instruction-fetch port and the load/store port. At most one access is
// granted per cycle; the one-cycle-latency read data is routed back to the
// port that issued the read. A saturating counter records contention cycles.
//
// Optional build macro ARB_ROUND_ROBIN_EN:
//   undefined : fixed priority, the data port wins every tie.
//   defined   : a 1-bit last-grant register makes ties alternate; it resets
//               to "data" so the first tie goes to fetch.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_halt,
    output logic [CNT_W-1:0] o_contention_cnt,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_IF = 2'd1,
        ST_RD_D  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_if_rvalid;
    logic             r_d_rvalid;
    logic [CNT_W-1:0] r_cnt;

    logic w_allow;
    logic w_tie;
    logic w_d_win;
    logic w_if_win;
    logic w_d_read;

    // Grants are never issued while halted or while reset is asserted.
    assign w_allow  = !rst && !i_halt;
    assign w_tie    = bus.if_req && bus.d_req;
    assign w_d_read = (bus.d_we == {BE_W{1'b0}});

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_if;

    // Tie-break: the port not granted last wins; a sole requester always wins.
    always_comb begin
        w_d_win  = w_allow && bus.d_req  && (!bus.if_req || r_last_if);
        w_if_win = w_allow && bus.if_req && (!bus.d_req  || !r_last_if);
    end

    // Remember which port took the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_if <= 1'b0;
        end else if (w_d_win || w_if_win) begin
            r_last_if <= w_if_win;
        end else begin
            r_last_if <= r_last_if;
        end
    end
`else
    // Fixed priority: the data port wins every tie.
    always_comb begin
        w_d_win  = w_allow && bus.d_req;
        w_if_win = w_allow && bus.if_req && !bus.d_req;
    end
`endif

    // Steer the winning port onto the memory; everything is zero with no winner.
    always_comb begin
        bus.if_gnt    = w_if_win;
        bus.d_gnt     = w_d_win;
        bus.mem_en    = 1'b0;
        bus.mem_we    = {BE_W{1'b0}};
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        if (w_d_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (w_if_win) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr;
        end else begin
            bus.mem_en = 1'b0;
        end
    end

    // Read tracking FSM: remembers which port owns the data returning next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
        end else if (w_d_win && w_d_read) begin
            r_state     <= ST_RD_D;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b1;
        end else if (w_if_win) begin
            r_state     <= ST_RD_IF;
            r_if_rvalid <= 1'b1;
            r_d_rvalid  <= 1'b0;
        end else begin
            r_state     <= ST_IDLE;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
        end
    end

    // Route memory read data to its owner; data lines stay zero when not valid.
    always_comb begin
        bus.if_rdata = {DATA_W{1'b0}};
        bus.d_rdata  = {DATA_W{1'b0}};
        case (r_state)
            ST_RD_IF: bus.if_rdata = bus.mem_rdata;
            ST_RD_D:  bus.d_rdata  = bus.mem_rdata;
            default:  bus.if_rdata = {DATA_W{1'b0}};
        endcase
    end

    assign bus.if_rvalid = r_if_rvalid;
    assign bus.d_rvalid  = r_d_rvalid;

    // Count cycles in which one requester loses to the other; saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_tie && !i_halt && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_contention_cnt = r_cnt;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the arbiter and memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk  = 1'b0;
    logic             rst  = 1'b1;
    logic             halt = 1'b0;
    logic [CNT_W-1:0] cnt;
    int               checks   = 0;
    int               failures = 0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_halt           (halt),
        .o_contention_cnt (cnt),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
        return 32'hC3A50000 ^ ({22'd0, a} * 32'h00010F1F);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Memory macro model: byte-enabled writes, one-cycle read latency.
    logic [31:0] env_mem [0:1023];
    logic [1023:0] env_wr = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we != 4'h0) begin
                env_mem[bus.mem_addr] <= merge(env_wr[bus.mem_addr] ? env_mem[bus.mem_addr]
                                               : init_val(bus.mem_addr), bus.mem_wdata, bus.mem_we);
                env_wr[bus.mem_addr]  <= 1'b1;
            end else begin
                bus.mem_rdata <= env_wr[bus.mem_addr] ? env_mem[bus.mem_addr] : init_val(bus.mem_addr);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0]      ref_mem [0:1023];
    logic [1023:0]    ref_wr;
    logic [CNT_W-1:0] m_cnt;
    bit               m_last_if;
    bit               m_if_rv, m_d_rv;
    logic [31:0]      m_rd;
    bit               e_if_gnt, e_d_gnt, e_en;
    logic [3:0]       e_we;
    logic [9:0]       e_addr;
    logic [31:0]      e_wdata, e_if_rdata, e_d_rdata;

    task automatic model_reset();
        ref_wr    = '0;
        m_cnt     = '0;
        m_last_if = 1'b0;
        m_if_rv   = 1'b0;
        m_d_rv    = 1'b0;
        m_rd      = 32'h0;
    endtask

    task automatic model_predict();
        e_if_gnt = 1'b0;
        e_d_gnt  = 1'b0;
        if (!rst && !halt) begin
            if (bus.d_req && bus.if_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (m_last_if) e_d_gnt = 1'b1; else e_if_gnt = 1'b1;
`else
                e_d_gnt = 1'b1;
`endif
            end else begin
                e_d_gnt  = bus.d_req;
                e_if_gnt = bus.if_req;
            end
        end
        e_en       = e_if_gnt || e_d_gnt;
        e_we       = e_d_gnt ? bus.d_we : 4'h0;
        e_addr     = e_d_gnt ? bus.d_addr : (e_if_gnt ? bus.if_addr : 10'd0);
        e_wdata    = e_d_gnt ? bus.d_wdata : 32'h0;
        e_if_rdata = m_if_rv ? m_rd : 32'h0;
        e_d_rdata  = m_d_rv ? m_rd : 32'h0;
    endtask

    task automatic model_commit();
        logic [31:0] cur;
        if (rst) begin
            model_reset();
        end else begin
            cur     = ref_wr[e_addr] ? ref_mem[e_addr] : init_val(e_addr);
            m_if_rv = e_if_gnt;
            m_d_rv  = e_d_gnt && (e_we == 4'h0);
            m_rd    = cur;
            if (e_d_gnt && e_we != 4'h0) begin
                ref_mem[e_addr] = merge(cur, e_wdata, e_we);
                ref_wr[e_addr]  = 1'b1;
            end
            if (bus.if_req && bus.d_req && !halt && m_cnt != CNT_MAX) m_cnt = m_cnt + 16'd1;
            if (e_en) m_last_if = e_if_gnt;
        end
    endtask

    task automatic settle();
        model_predict();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.if_req = 1'b1; bus.if_addr = 10'd3;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 10'd5; bus.d_wdata = 32'h0;
        model_reset();
        @(negedge clk);
        checks++; if (bus.if_gnt !== 1'b0) begin failures++; $display("FAIL rst_if_gnt got %b want 0", bus.if_gnt); end
        checks++; if (bus.d_gnt !== 1'b0) begin failures++; $display("FAIL rst_d_gnt got %b want 0", bus.d_gnt); end
        checks++; if (bus.mem_en !== 1'b0 || bus.mem_addr !== 10'd0) begin failures++; $display("FAIL rst_mem got en=%b addr=%h want 0", bus.mem_en, bus.mem_addr); end
        checks++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got %b%b want 00", bus.if_rvalid, bus.d_rvalid); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt got %0d want 0", cnt); end
        // release, issue one data read, then reset while it is in flight
        @(posedge clk); #1;
        rst = 1'b0; bus.if_req = 1'b0;
        settle();
        checks++; if (bus.d_gnt !== 1'b1) begin failures++; $display("FAIL rst_first_gnt got %b want 1", bus.d_gnt); end
        step();
        rst = 1'b1; #1;
        checks++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin failures++; $display("FAIL rst_midread got v=%b d=%h want 0", bus.d_rvalid, bus.d_rdata); end
        checks++; if (bus.mem_en !== 1'b0 || bus.d_gnt !== 1'b0) begin failures++; $display("FAIL rst_midread_comb got en=%b gnt=%b want 0", bus.mem_en, bus.d_gnt); end
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; model_reset();
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_post_rvalid[%0d] got %b%b want 00", i, bus.if_rvalid, bus.d_rvalid); end
            step();
        end
    endtask

    task automatic test_fetch_only();
        bus.d_req = 1'b1; bus.d_we = 4'hF; bus.d_addr = 10'h004; bus.d_wdata = 32'h12345678;
        settle();
        step();
        bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 10'h004;
        settle();
        checks++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin failures++; $display("FAIL fetch_gnt got if=%b d=%b want 1/0", bus.if_gnt, bus.d_gnt); end
        checks++; if (bus.mem_addr !== 10'h004 || bus.mem_we !== 4'h0) begin failures++; $display("FAIL fetch_mem got addr=%h we=%h want 004/0", bus.mem_addr, bus.mem_we); end
        checks++; if (bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL write_no_rvalid got %b want 0", bus.d_rvalid); end
        step();
        bus.if_req = 1'b0;
        settle();
        checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h12345678) begin failures++; $display("FAIL fetch_data got v=%b d=%h want 1/12345678", bus.if_rvalid, bus.if_rdata); end
        checks++; if (bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_d_rvalid got %b want 0", bus.d_rvalid); end
        step();
    endtask

    task automatic test_tie();
        bit first_d;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 10'h010;
        bus.if_req = 1'b1; bus.if_addr = 10'h020;
        settle();
`ifndef ARB_ROUND_ROBIN_EN
        checks++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin failures++; $display("FAIL tie_prio got d=%b if=%b want 1/0", bus.d_gnt, bus.if_gnt); end
`endif
        checks++; if (bus.d_gnt !== e_d_gnt || bus.if_gnt !== e_if_gnt) begin failures++; $display("FAIL tie_first got d=%b if=%b want %b/%b", bus.d_gnt, bus.if_gnt, e_d_gnt, e_if_gnt); end
        first_d = e_d_gnt;
        step();
        if (first_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
        settle();
        checks++; if (bus.d_gnt !== !first_d || bus.if_gnt !== first_d) begin failures++; $display("FAIL tie_second got d=%b if=%b", bus.d_gnt, bus.if_gnt); end
        checks++; if (first_d ? (bus.d_rvalid !== 1'b1 || bus.d_rdata !== init_val(10'h010))
                              : (bus.if_rvalid !== 1'b1 || bus.if_rdata !== init_val(10'h020))) begin
            failures++; $display("FAIL tie_rdata1 got d=%b/%h if=%b/%h", bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata); end
        step();
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        settle();
        checks++; if (first_d ? (bus.if_rvalid !== 1'b1 || bus.if_rdata !== init_val(10'h020) || bus.d_rvalid !== 1'b0)
                              : (bus.d_rvalid !== 1'b1 || bus.d_rdata !== init_val(10'h010) || bus.if_rvalid !== 1'b0)) begin
            failures++; $display("FAIL tie_rdata2 got d=%b/%h if=%b/%h", bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata); end
        checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL tie_cnt got %0d want 1", cnt); end
        step();
    endtask

    task automatic test_store_load();
        bus.d_req = 1'b1; bus.d_we = 4'hF; bus.d_addr = 10'h030; bus.d_wdata = 32'h11112222;
        settle();
        step();
        bus.d_we = 4'b0011; bus.d_wdata = 32'hAAAABBBB;
        settle();
        checks++; if (bus.d_rvalid !== 1'b0 || bus.mem_we !== 4'b0011) begin failures++; $display("FAIL store_cycle got v=%b we=%h want 0/3", bus.d_rvalid, bus.mem_we); end
        step();
        bus.d_we = 4'h0;
        settle();
        checks++; if (bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL store_no_rvalid got %b want 0", bus.d_rvalid); end
        step();
        bus.d_req = 1'b0;
        settle();
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1111BBBB) begin failures++; $display("FAIL load_merge got v=%b d=%h want 1/1111bbbb", bus.d_rvalid, bus.d_rdata); end
        step();
    endtask

    task automatic test_halt();
        logic [CNT_W-1:0] cnt0;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 10'h030;
        settle();
        step();
        halt = 1'b1; bus.if_req = 1'b1; bus.if_addr = 10'h007; bus.d_addr = 10'h031;
        cnt0 = m_cnt;
        settle();
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1111BBBB) begin failures++; $display("FAIL halt_inflight got v=%b d=%h want 1/1111bbbb", bus.d_rvalid, bus.d_rdata); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin failures++; $display("FAIL halt_gnt[%0d] got if=%b d=%b en=%b want 0", i, bus.if_gnt, bus.d_gnt, bus.mem_en); end
            step();
            settle();
        end
        checks++; if (cnt !== cnt0) begin failures++; $display("FAIL halt_cnt got %0d want %0d", cnt, cnt0); end
        halt = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if (!bus.if_req || e_if_gnt) begin
                bus.if_req  = ($urandom_range(2) != 0);
                bus.if_addr = 10'($urandom_range(15));
            end
            if (!bus.d_req || e_d_gnt) begin
                bus.d_req   = ($urandom_range(2) != 0);
                bus.d_addr  = 10'($urandom_range(15));
                bus.d_we    = $urandom_range(1) ? 4'h0 : 4'($urandom_range(15));
                bus.d_wdata = $urandom;
            end
            halt = ($urandom_range(5) == 0);
            settle();
            checks++; if (bus.if_gnt !== e_if_gnt || bus.d_gnt !== e_d_gnt) begin failures++; $display("FAIL rnd_gnt[%0d] got if=%b d=%b want %b/%b", n, bus.if_gnt, bus.d_gnt, e_if_gnt, e_d_gnt); end
            checks++; if (bus.mem_en !== e_en || bus.mem_we !== e_we || bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata) begin
                failures++; $display("FAIL rnd_mem[%0d] got en=%b we=%h a=%h wd=%h want %b/%h/%h/%h", n, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, e_en, e_we, e_addr, e_wdata); end
            checks++; if (bus.if_rvalid !== m_if_rv || bus.if_rdata !== e_if_rdata) begin failures++; $display("FAIL rnd_if_rd[%0d] got %b/%h want %b/%h", n, bus.if_rvalid, bus.if_rdata, m_if_rv, e_if_rdata); end
            checks++; if (bus.d_rvalid !== m_d_rv || bus.d_rdata !== e_d_rdata) begin failures++; $display("FAIL rnd_d_rd[%0d] got %b/%h want %b/%h", n, bus.d_rvalid, bus.d_rdata, m_d_rv, e_d_rdata); end
            checks++; if (cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, cnt, m_cnt); end
            step();
        end
        halt = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        bus.if_req = 1'b1; bus.if_addr = 10'h001;
        bus.d_req = 1'b1; bus.d_we = 4'h0; bus.d_addr = 10'h002;
        for (int n = 0; n < (1 << CNT_W) + 5; n++) begin
            settle();
            checks++; if (bus.if_gnt !== e_if_gnt || bus.d_gnt !== e_d_gnt) begin failures++; $display("FAIL sat_gnt[%0d] got if=%b d=%b want %b/%b", n, bus.if_gnt, bus.d_gnt, e_if_gnt, e_d_gnt); end
            step();
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        settle();
        checks++; if (cnt !== CNT_MAX) begin failures++; $display("FAIL sat_cnt got %h want %h", cnt, CNT_MAX); end
        step();
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 10'd0;
        bus.d_req = 1'b0; bus.d_we = 4'h0; bus.d_addr = 10'd0; bus.d_wdata = 32'h0;
        test_reset();
        test_fetch_only();
        test_tie();
        test_store_load();
        test_halt();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
